// File: rtl/cache_pkg.sv
// Shared cache-line interface constants and the adaptor state type, used by the
// L2 controller, its datapath and the memory-side cache-line adaptor.
package cache_pkg;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int BEATS   = LINE_W / BURST_W;
  localparam int ADDR_W  = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD_BURST,
    RD_DONE,
    WR_BURST,
    WR_DONE
  } cla_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Memory-side responder for the L2 cache-line interface: turns one line read or
// write into a BEATS-long burst of BURST_W beats and pulses resp_o when done.
module cacheline_adaptor #(
  parameter int LINE_W  = cache_pkg::LINE_W,
  parameter int BURST_W = cache_pkg::BURST_W,
  parameter int ADDR_W  = cache_pkg::ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);
  import cache_pkg::*;

  localparam int NBEATS = LINE_W / BURST_W;
  localparam int CNT_W  = $clog2(NBEATS);
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  cla_state_t                    state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;
  logic [NBEATS-1:0][BURST_W-1:0] wr_line_q, wr_line_d;
  logic [NBEATS-1:0][BURST_W-1:0] rd_line_q, rd_line_d;
  logic [ADDR_W-1:0]             addr_aligned;

  assign addr_aligned = {address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wr_line_d = wr_line_q;
    rd_line_d = rd_line_q;

    unique case (state_q)
      IDLE: begin
        // A write-back must drain before the refill, so write has priority.
        if (write_i) begin
          wr_line_d = line_i;
          addr_d    = addr_aligned;
          cnt_d     = '0;
          state_d   = WR_BURST;
        end else if (read_i) begin
          addr_d    = addr_aligned;
          cnt_d     = '0;
          state_d   = RD_BURST;
        end
      end
      RD_BURST: begin
        if (resp_i) begin
          rd_line_d[cnt_q] = burst_i;
          cnt_d            = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) state_d = RD_DONE;
        end
      end
      WR_BURST: begin
        if (resp_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) state_d = WR_DONE;
        end
      end
      RD_DONE,
      WR_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  // The line registers are reset as well: line_o and burst_o must read 0
  // out of reset, and an aborted read must not leave stale beats visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wr_line_q <= '0;
      rd_line_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wr_line_q <= wr_line_d;
      rd_line_q <= rd_line_d;
    end
  end

  // Outputs come only from registers and state, never from *_i directly.
  assign read_o    = (state_q == RD_BURST);
  assign write_o   = (state_q == WR_BURST);
  assign resp_o    = (state_q == RD_DONE) || (state_q == WR_DONE);
  assign address_o = addr_q;
  assign burst_o   = wr_line_q[cnt_q];
  assign line_o    = rd_line_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: table of line transactions with a
// beat/line scoreboard, plus hand-written reset and spurious-strobe sequences.
module tb_cacheline_adaptor;

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rd;
    logic         wr;
    logic         b2b;       // start in the cycle right after the previous resp_o
    logic [31:0]  addr;
    logic [31:0]  exp_addr;
    logic [255:0] wline;
    logic [255:0] rline;     // memory beats are its 64-bit slices, beat 0 lowest
    logic [7:0]   mask;      // resp_i per burst cycle, bit 0 first; 1 afterwards
    int           exp_lat;
  } txn_t;

  txn_t tbl[5];

  int checks   = 0;
  int failures = 0;

  logic [63:0]  beat_sb[$];
  logic [255:0] line_sb[$];

  logic [255:0] last_rline;
  logic [255:0] last_wline;
  logic [31:0]  last_addr;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input txn_t t);
    int          edges = 0;
    int          taken = 0;
    int          cyc   = 0;
    logic        r;
    logic [63:0] exp_beat;

    read_i    = t.rd;
    write_i   = t.wr;
    address_i = t.addr;
    line_i    = t.wline;
    resp_i    = 1'b0;
    if (t.wr) for (int b = 0; b < 4; b++) beat_sb.push_back(t.wline[b*64 +: 64]);
    else      line_sb.push_back(t.rline);

    tick();
    edges = 1;
    check("accept_dir", {30'd0, read_o, write_o}, t.wr ? 32'd1 : 32'd2);
    check("address_o",  address_o, t.exp_addr);
    address_i = 32'hFFFF_FFFF;
    line_i    = {8{32'hBAD0_BAD0}};

    while (taken < 4 && cyc < 32) begin
      r       = (cyc < 8) ? t.mask[cyc] : 1'b1;
      resp_i  = r;
      burst_i = r ? t.rline[taken*64 +: 64] : 64'hDEAD_BEEF_DEAD_BEEF;
      check("burst_dir", {30'd0, read_o, write_o}, t.wr ? 32'd1 : 32'd2);
      check("resp_early", resp_o, 1'b0);
      if (t.wr) begin
        if (beat_sb.size() == 0) check("beat_sb_empty", 1'b1, 1'b0);
        else begin
          exp_beat = r ? beat_sb.pop_front() : beat_sb[0];
          check(r ? "burst_o" : "burst_o_stall", burst_o, exp_beat);
        end
      end
      tick();
      edges++;
      cyc++;
      if (r) taken++;
    end
    resp_i  = 1'b0;
    burst_i = 64'h0;
    if (taken < 4) check("burst_timeout", 32'(taken), 32'd4);

    check("resp_o",      resp_o, 1'b1);
    check("latency",     32'(edges + 1), 32'(t.exp_lat));
    check("done_dir",    {30'd0, read_o, write_o}, 32'd0);
    check("addr_held",   address_o, t.exp_addr);
    if (t.wr) begin
      check("line_o_kept", line_o, last_rline);
      last_wline = t.wline;
    end else begin
      if (line_sb.size() == 0) check("line_sb_empty", 1'b1, 1'b0);
      else check("line_o", line_o, line_sb.pop_front());
      last_rline = t.rline;
    end
    last_addr = t.exp_addr;

    // Request is still held across the DONE edge; it must not be re-accepted.
    tick();
    check("resp_pulse",  resp_o, 1'b0);
    check("done_noacc",  {30'd0, read_o, write_o}, 32'd0);
    read_i  = 1'b0;
    write_i = 1'b0;
  endtask

  initial begin
    txn_t t;

    tbl[0] = '{rd: 1'b1, wr: 1'b0, b2b: 1'b0, addr: 32'h0000_1234, exp_addr: 32'h0000_1220,
               wline: '0,
               rline: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
               mask: 8'hFF, exp_lat: 6};
    tbl[1] = '{rd: 1'b0, wr: 1'b1, b2b: 1'b0, addr: 32'hABCD_EF7F, exp_addr: 32'hABCD_EF60,
               wline: {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                       64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
               rline: '0, mask: 8'h65, exp_lat: 9};
    tbl[2] = '{rd: 1'b1, wr: 1'b1, b2b: 1'b0, addr: 32'h0000_003F, exp_addr: 32'h0000_0020,
               wline: {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                       64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0},
               rline: '0, mask: 8'hFF, exp_lat: 6};
    tbl[3] = '{rd: 1'b1, wr: 1'b0, b2b: 1'b1, addr: 32'hCAFE_BABE, exp_addr: 32'hCAFE_BAA0,
               wline: '0,
               rline: {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                       64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555},
               mask: 8'hFF, exp_lat: 6};
    tbl[4] = '{rd: 1'b1, wr: 1'b0, b2b: 1'b0, addr: 32'h0000_0040, exp_addr: 32'h0000_0040,
               wline: '0,
               rline: {64'h1357_9BDF_0246_8ACE, 64'h0000_0000_FFFF_FFFF,
                       64'h8000_0000_0000_0001, 64'h5A5A_A5A5_5A5A_A5A5},
               mask: 8'h36, exp_lat: 8};

    rst = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    address_i = '0; line_i = '0; burst_i = '0;
    last_rline = '0; last_wline = '0; last_addr = '0;

    #3;
    check("rst_dir",     {29'd0, read_o, write_o, resp_o}, 32'd0);
    check("rst_addr",    address_o, 32'd0);
    check("rst_burst",   burst_o, 64'd0);
    check("rst_line",    line_o, 256'd0);
    #9 rst = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      if (!tbl[i].b2b) tick();
      run_txn(tbl[i]);
    end

    // Spurious strobes while idle must not move the counter or any output.
    tick();
    for (int i = 0; i < 3; i++) begin
      resp_i  = 1'b1;
      burst_i = 64'h9999_0000_9999_0000 + 64'(i);
      tick();
      check("idle_dir",   {29'd0, read_o, write_o, resp_o}, 32'd0);
      check("idle_line",  line_o, last_rline);
      check("idle_addr",  address_o, last_addr);
      check("idle_burst", burst_o, last_wline[63:0]);
    end
    resp_i = 1'b0;
    tick();
    t = tbl[0];
    t.addr = 32'h0000_2000; t.exp_addr = 32'h0000_2000;
    t.rline = {64'hA1A1_A1A1_A1A1_A1A1, 64'hB2B2_B2B2_B2B2_B2B2,
               64'hC3C3_C3C3_C3C3_C3C3, 64'hD4D4_D4D4_D4D4_D4D4};
    run_txn(t);

    // Reset asserted mid-read with beat 2 pending.
    tick();
    read_i = 1'b1; address_i = 32'h0000_0100;
    tick();
    for (int b = 0; b < 2; b++) begin
      resp_i = 1'b1; burst_i = 64'hEEEE_0000_0000_0000 + 64'(b);
      tick();
    end
    resp_i = 1'b0;
    check("pre_rst_read", read_o, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("async_read_o", read_o, 1'b0);
    check("async_resp_o", resp_o, 1'b0);
    check("async_line",   line_o, 256'd0);
    check("async_addr",   address_o, 32'd0);
    read_i = 1'b0;
    tick();
    tick();
    #3 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_quiet", {29'd0, read_o, write_o, resp_o}, 32'd0);
    end
    last_rline = '0; last_wline = '0; last_addr = '0;
    t = tbl[0];
    t.addr = 32'h0000_0100; t.exp_addr = 32'h0000_0100;
    t.rline = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
               64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
    run_txn(t);

    if (beat_sb.size() != 0 || line_sb.size() != 0)
      check("sb_leftover", 32'(beat_sb.size() + line_sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Direction exclusivity holds on every cycle, not just the checked ones.
  always @(negedge clk) begin
    if (read_o && write_o) check("rd_wr_both", {read_o, write_o}, 2'b00);
  end

endmodule
